// File: rtl/nvram_upload.sv
// Serves HPS upload reads from an NVRAM image held in a synchronous RAM.
// The game core is paused first so the RAM contents stay stable for the whole session.
module nvram_upload #(
  parameter int         INDEX = 4,
  parameter int         AW    = 10,
  parameter int         SIZE  = 1024,
  parameter logic [7:0] FILL  = 8'hFF
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          ioctl_upload,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_rd,
  input  logic [24:0]   ioctl_addr,
  output logic [7:0]    ioctl_din,
  output logic          ioctl_wait,
  output logic          pause_req,
  input  logic          pause_ack,
  output logic [AW-1:0] ram_addr,
  output logic          ram_rd,
  input  logic [7:0]    ram_q,
  output logic          done
);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    READY,
    FETCH,
    LATCH
  } state_t;

  state_t state;
  logic   oor;
  logic   sel;

  assign sel = ioctl_upload && (ioctl_index == INDEX[7:0]);

  // A strobe in READY raises wait the same cycle, so the HPS never sees a zero gap.
  assign ioctl_wait = (state == ARM) || (state == FETCH) || (state == LATCH) ||
                      ((state == READY) && (ioctl_rd || !pause_ack));

  assign ram_rd = (state == FETCH);

  // Losing sel ends the session from any state; losing pause_ack only stalls it.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      ioctl_din <= 8'h00;
      pause_req <= 1'b0;
      done      <= 1'b0;
      ram_addr  <= '0;
      oor       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != IDLE && !sel) begin
        state     <= IDLE;
        pause_req <= 1'b0;
        done      <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (sel) begin
              state     <= ARM;
              pause_req <= 1'b1;
            end
          end
          ARM: begin
            if (pause_ack) state <= READY;
          end
          READY: begin
            if (pause_ack && ioctl_rd) begin
              state    <= FETCH;
              ram_addr <= ioctl_addr[AW-1:0];
              oor      <= (ioctl_addr >= 25'(SIZE));
            end
          end
          FETCH: begin
            if (pause_ack) state <= LATCH;
          end
          LATCH: begin
            if (pause_ack) begin
              ioctl_din <= oor ? FILL : ram_q;
              state     <= READY;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nvram_upload.sv
// Randomised bench for nvram_upload: a RAM model feeds the DUT, a reference model predicts
// each returned byte, and a monitor compares it whenever the HPS stall releases after a read.
module tb_nvram_upload;

  localparam int         SIZE = 1024;
  localparam logic [7:0] FILL = 8'hFF;

  logic        clk;
  logic        reset_n;
  logic        ioctl_upload;
  logic [7:0]  ioctl_index;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        pause_req;
  logic        pause_ack;
  logic [9:0]  ram_addr;
  logic        ram_rd;
  logic [7:0]  ram_q;
  logic        done;

  logic [7:0]  mem [SIZE];
  logic [7:0]  exp_q [$];
  logic [7:0]  last_din;
  int          checks;
  int          passes;

  nvram_upload #(.INDEX(4), .AW(10), .SIZE(SIZE), .FILL(FILL)) dut (
    .CLK         (clk),
    .RESET_N     (reset_n),
    .ioctl_upload(ioctl_upload),
    .ioctl_index (ioctl_index),
    .ioctl_rd    (ioctl_rd),
    .ioctl_addr  (ioctl_addr),
    .ioctl_din   (ioctl_din),
    .ioctl_wait  (ioctl_wait),
    .pause_req   (pause_req),
    .pause_ack   (pause_ack),
    .ram_addr    (ram_addr),
    .ram_rd      (ram_rd),
    .ram_q       (ram_q),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_rd) ram_q <= mem[ram_addr];
  end

  function automatic logic [7:0] ref_byte(input logic [24:0] a);
    logic [9:0] idx;
    idx = a[9:0];
    return (a >= 25'(SIZE)) ? FILL : mem[idx];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // A completed read shows up as wait falling while the core is still paused.
  initial begin : monitor
    logic prev_wait;
    prev_wait = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_wait && !ioctl_wait && pause_req && exp_q.size() > 0)
        checkOutput("scoreboard_din", 32'(ioctl_din), 32'(exp_q.pop_front()));
      prev_wait = ioctl_wait;
    end
  end

  task automatic startSession(input int ack_delay);
    @(negedge clk);
    ioctl_index  = 8'd4;
    ioctl_upload = 1'b1;
    pause_ack    = 1'b0;
    @(posedge clk);
    for (int i = 0; i < ack_delay; i++) begin
      @(negedge clk);
      checkOutput("wait_in_arm", 32'(ioctl_wait), 32'd1);
      checkOutput("pause_req_in_arm", 32'(pause_req), 32'd1);
    end
    pause_ack = 1'b1;
    @(negedge clk);
    checkOutput("wait_ready", 32'(ioctl_wait), 32'd0);
  endtask

  task automatic endSession();
    @(negedge clk);
    ioctl_upload = 1'b0;
    @(negedge clk);
    checkOutput("done_pulse", 32'(done), 32'd1);
    checkOutput("pause_req_end", 32'(pause_req), 32'd0);
    pause_ack = 1'b0;
    @(negedge clk);
    checkOutput("done_single", 32'(done), 32'd0);
  endtask

  task automatic applyStimulus(input logic [24:0] addr, input bit second, input logic [24:0] addr2);
    logic [7:0] exp;
    int pulses;
    exp = ref_byte(addr);
    @(negedge clk);
    ioctl_rd   = 1'b1;
    ioctl_addr = addr;
    exp_q.push_back(exp);
    #1 checkOutput("wait_on_strobe", 32'(ioctl_wait), 32'd1);
    pulses = 0;
    @(negedge clk);
    if (ram_rd) pulses++;
    checkOutput("wait_in_fetch", 32'(ioctl_wait), 32'd1);
    if (second) ioctl_addr = addr2;
    else ioctl_rd = 1'b0;
    @(negedge clk);
    ioctl_rd = 1'b0;
    if (ram_rd) pulses++;
    checkOutput("din_before_latency", 32'(ioctl_din), 32'(last_din));
    @(negedge clk);
    if (ram_rd) pulses++;
    checkOutput("read_data", 32'(ioctl_din), 32'(exp));
    checkOutput("ram_rd_pulses", 32'(pulses), 32'd1);
    last_din = exp;
  endtask

  initial begin
    logic [24:0] a;
    int budget;
    checks = 0;
    passes = 0;
    last_din = 8'h00;
    reset_n = 1'b1;
    ioctl_upload = 1'b0;
    ioctl_index = 8'd0;
    ioctl_rd = 1'b0;
    ioctl_addr = '0;
    pause_ack = 1'b0;
    for (int i = 0; i < SIZE; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h5A;
    mem[7] = ~mem[3];

    #2 reset_n = 1'b0;
    #1;
    checkOutput("reset_din", 32'(ioctl_din), 32'h0);
    checkOutput("reset_pause_req", 32'(pause_req), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_ram_addr", 32'(ram_addr), 32'd0);
    checkOutput("reset_ram_rd", 32'(ram_rd), 32'd0);
    checkOutput("reset_wait", 32'(ioctl_wait), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("release_no_done", 32'(done), 32'd0);

    $display("[TB] basic session");
    startSession(5);
    applyStimulus(25'd0, 1'b0, 25'd0);
    checkOutput("wait_after_read", 32'(ioctl_wait), 32'd0);

    $display("[TB] out of range and boundaries");
    applyStimulus(25'd1024, 1'b0, 25'd0);
    applyStimulus(25'd1023, 1'b0, 25'd0);
    applyStimulus(25'h1FFFFFF, 1'b0, 25'd0);

    $display("[TB] back-to-back strobes");
    applyStimulus(25'd3, 1'b1, 25'd7);

    $display("[TB] random reads");
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0) a = 25'($urandom);
      else a = 25'($urandom_range(0, SIZE - 1));
      applyStimulus(a, 1'b0, 25'd0);
    end

    $display("[TB] pause_ack drop during fetch");
    a = 25'($urandom_range(0, SIZE - 1));
    @(negedge clk);
    ioctl_rd = 1'b1;
    ioctl_addr = a;
    exp_q.push_back(ref_byte(a));
    @(negedge clk);
    ioctl_rd = 1'b0;
    pause_ack = 1'b0;
    @(negedge clk);
    checkOutput("ram_rd_held", 32'(ram_rd), 32'd1);
    checkOutput("wait_held", 32'(ioctl_wait), 32'd1);
    pause_ack = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("read_after_hold", 32'(ioctl_din), 32'(ref_byte(a)));
    last_din = ref_byte(a);
    endSession();

    $display("[TB] mid-fetch abort");
    startSession(2);
    @(negedge clk);
    ioctl_rd = 1'b1;
    ioctl_addr = 25'd5;
    @(negedge clk);
    ioctl_rd = 1'b0;
    ioctl_upload = 1'b0;
    @(negedge clk);
    checkOutput("abort_done", 32'(done), 32'd1);
    checkOutput("abort_pause_req", 32'(pause_req), 32'd0);
    checkOutput("abort_din_kept", 32'(ioctl_din), 32'(last_din));
    checkOutput("abort_wait", 32'(ioctl_wait), 32'd0);
    pause_ack = 1'b0;
    @(negedge clk);
    checkOutput("abort_done_single", 32'(done), 32'd0);

    $display("[TB] wrong index");
    ioctl_index = 8'd3;
    ioctl_upload = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ioctl_rd = i[0];
      ioctl_addr = 25'(i);
      #1;
      checkOutput("wrong_idx_pause_req", 32'(pause_req), 32'd0);
      checkOutput("wrong_idx_wait", 32'(ioctl_wait), 32'd0);
    end
    @(negedge clk);
    ioctl_rd = 1'b0;
    ioctl_upload = 1'b0;
    ioctl_index = 8'd4;

    $display("[TB] reset mid-session");
    startSession(1);
    @(negedge clk);
    ioctl_rd = 1'b1;
    ioctl_addr = 25'd9;
    @(negedge clk);
    ioctl_rd = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_din", 32'(ioctl_din), 32'h0);
    checkOutput("midrst_pause_req", 32'(pause_req), 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    checkOutput("midrst_wait", 32'(ioctl_wait), 32'd0);
    checkOutput("midrst_ram_rd", 32'(ram_rd), 32'd0);
    last_din = 8'h00;
    @(negedge clk);
    checkOutput("midrst_no_done", 32'(done), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("rearm_pause_req", 32'(pause_req), 32'd1);
    checkOutput("rearm_wait", 32'(ioctl_wait), 32'd1);
    checkOutput("rearm_no_done", 32'(done), 32'd0);
    @(negedge clk);
    applyStimulus(25'd0, 1'b0, 25'd0);
    endSession();

    budget = 0;
    while (exp_q.size() > 0 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/nvram_upload.md
NVRAM_UPLOAD -- requirements
Module: nvram_upload

Interface
REQ-001 The block SHALL have parameters: INDEX, default 4, ioctl_index value that selects this block; AW, default 10, RAM address width; SIZE, default 1024, number of valid bytes; FILL, default 8'hFF, byte returned for addresses >= SIZE.
REQ-002 The block SHALL have the following ports: CLK  in  1  single system clock; all logic is on its rising edge.
REQ-003 RESET_N  in  1  asynchronous, active-low reset.
REQ-004 ioctl_upload  in  1  HPS upload session active.
REQ-005 ioctl_index  in  8  upload target index.
REQ-006 ioctl_rd  in  1  one-cycle read strobe from HPS.
REQ-007 ioctl_addr  in  25  byte address of the read.
REQ-008 ioctl_din  out  8  byte returned to HPS.
REQ-009 ioctl_wait  out  1  HPS stall request.
REQ-010 pause_req  out  1  request to the game core to freeze its CPU.
REQ-011 pause_ack  in  1  game core is frozen and the RAM is stable.
REQ-012 ram_addr  out  AW  read address to the synchronous RAM port.
REQ-013 ram_rd  out  1  RAM read enable.
REQ-014 ram_q  in  8  RAM data, valid one cycle after ram_rd.
REQ-015 done  out  1  one-cycle pulse at the end of a session.

Function
REQ-016 The session qualifier SHALL be sel = ioctl_upload && (ioctl_index == INDEX).
REQ-017 The state machine SHALL have the states IDLE, ARM, READY, FETCH and LATCH.
REQ-018 IDLE -> ARM on sel, with pause_req set to 1 on the same edge.
REQ-019 ARM -> READY on the first cycle pause_ack is sampled 1.
  - ioctl_wait SHALL be 1 throughout ARM.
REQ-020 READY: ioctl_rd=1 SHALL cause a transition to FETCH.
  - Same edge: ram_addr <= ioctl_addr[AW-1:0].
  - Same edge: the range flag oor <= (ioctl_addr >= SIZE), compared on the full 25 bits.
REQ-021 FETCH: ram_rd SHALL be 1 for exactly this one cycle; next state LATCH.
REQ-022 LATCH: ioctl_din <= (oor ? FILL : ram_q); next state READY.
REQ-023 Read latency SHALL be 3 edges from the edge that samples ioctl_rd to ioctl_din valid.
REQ-024 ioctl_wait SHALL be combinational: 1 when the state is ARM, FETCH or LATCH, or when (state == READY && ioctl_rd).
  - This leaves no zero gap on the cycle the strobe arrives.
REQ-025 An ioctl_rd arriving in ARM, FETCH or LATCH SHALL be ignored: no state change and no address capture.
REQ-026 ioctl_rd outside a session (IDLE) SHALL be ignored.
REQ-027 Falling sel in any non-IDLE state SHALL abort immediately:
  - next state IDLE; pause_req <= 0; any fetch in progress is discarded;
  - ioctl_din holds its last value; done <= 1 for one cycle.
REQ-028 sel still high in IDLE on the cycle after done SHALL start a new session (re-ARM).
REQ-029 pause_ack dropping during READY, FETCH or LATCH SHALL NOT abort, but SHALL hold the state until pause_ack returns.
  - ioctl_wait = 1 while held.
  - A FETCH held this way SHALL keep ram_rd = 1 and re-read the RAM.
REQ-030 Address wrap: bits of ioctl_addr above AW SHALL NOT alias into the RAM when the address is >= SIZE; FILL is returned instead.
REQ-031 ram_rd SHALL be 0 in every state other than FETCH.

Reset
REQ-032 While RESET_N = 0, the block SHALL hold: state IDLE; ioctl_din 8'h00; pause_req 0; done 0; ram_addr 0; ram_rd 0; oor 0; ioctl_wait 0 (combinational, state-derived).
REQ-033 On RESET_N release, the block SHALL resume on the first rising CLK edge with no spurious done pulse.
REQ-034 Reset asserted mid-session SHALL return the block to its reset values immediately, without producing a done pulse.

Verification
REQ-035 Basic session:
  - Stimulus: index=4, upload rises; pause_ack arrives 5 cycles later; RAM[0]=8'h5A; strobe rd at addr 0.
  - Required: ioctl_wait is 1 for those 5 cycles; ioctl_din = 8'h5A 3 edges after rd; ioctl_wait then 0.
REQ-036 Out of range:
  - Stimulus: rd at addr 1024 (SIZE=1024) with RAM[0]=8'h5A.
  - Required: ioctl_din = 8'hFF; ram_rd pulses once; aliased data is not returned.
REQ-037 Back-to-back strobes:
  - Stimulus: rd at addr 3, then another rd one cycle later.
  - Required: the second rd is ignored; ioctl_din = RAM[3]; exactly one ram_rd pulse.
REQ-038 Mid-fetch abort:
  - Stimulus: upload falls during FETCH.
  - Required: the next cycle is IDLE with pause_req = 0 and done = 1 for one cycle; ioctl_din is unchanged.
REQ-039 Wrong index:
  - Stimulus: index=3 with upload = 1 and rd strobes.
  - Required: the block stays in IDLE with pause_req = 0 and ioctl_wait = 0.
REQ-040 Reset mid-session:
  - Stimulus: RESET_N low during LATCH.
  - Required: outputs immediately take their reset values and done is not pulsed.
  - After release with sel high: ARM is re-entered on the next edge.
